// File: rtl/y_stream_mux.sv
// y_stream_mux: N-to-1 stream multiplexer with a single output register.
// Channel choice is either the manual select or a round-robin search that
// starts at the channel after the last accepted one. Every accepted input
// word is counted in a free-running 16-bit counter.
//
// Handshake: a word moves across an interface on a rising edge where its
// valid and ready are both high. Valid never waits on ready. in_ready is a
// combinational function of mode/sel/in_valid/out_valid/out_ready and the
// round-robin pointer. It is one-hot on the granted channel or all zero.
module y_stream_mux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    localparam int CW      = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [CW-1:0]             sel,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [CW-1:0]             out_chan,
    input  logic                      out_ready,
    output logic [15:0]               xfer_count
);

    // Round-robin search origin: the channel after the last accepted one.
    logic [CW-1:0]    ptr;

    logic [CW-1:0]    cand;
    logic             grant;
    logic             space;
    logic             accept;
    logic [WIDTH-1:0] words [CHANNELS];
    logic [WIDTH-1:0] sel_word;

    // Unpack the flat data bus so the granted word is a plain array read.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_words
        assign words[i] = in_data[i*WIDTH +: WIDTH];
    end

    // Pick the candidate channel and decide whether it holds a word.
    always_comb begin
        logic [CW-1:0] idx;
        cand  = ptr;
        grant = 1'b0;
        idx   = '0;
        if (!mode) begin
            cand  = sel;
            grant = in_valid[sel];
        end else begin
            // The pointer is CW bits wide and CHANNELS is a power of two,
            // so the addition wraps modulo CHANNELS by itself.
            for (int k = 0; k < CHANNELS; k++) begin
                idx = ptr + CW'(k);
                if (!grant && in_valid[idx]) begin
                    cand  = idx;
                    grant = 1'b1;
                end
            end
        end
    end

    // The output register can take a word if it is empty or draining now.
    assign space    = !out_valid || out_ready;
    assign accept   = grant && space;
    assign sel_word = words[cand];

    // One-hot accept toward the granted channel; silent while in reset.
    always_comb begin
        in_ready = '0;
        if (accept && rst_n) begin
            in_ready[cand] = 1'b1;
        end
    end

    // Output register, pointer and counter. A load has priority over a
    // drain so a simultaneous drain and accept never leaves a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_chan   <= '0;
            ptr        <= '0;
            xfer_count <= '0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_data   <= sel_word;
            out_chan   <= cand;
            ptr        <= cand + 1'b1;
            xfer_count <= xfer_count + 16'd1;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_y_stream_mux.sv
// Bench for y_stream_mux (WIDTH=8, CHANNELS=4). A driver issues one input
// vector per cycle, predicts the response from the grant/space rules and
// queues each accepted word. A separate monitor pops the queue whenever the
// DUT drains a word and compares channel and data.
module tb_y_stream_mux;

  localparam int W  = 8;
  localparam int C  = 4;
  localparam int CW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           mode = 1'b0;
  logic [CW-1:0]  sel = '0;
  logic [C-1:0]   in_valid = '0;
  logic [C*W-1:0] in_data = '0;
  logic [C-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [CW-1:0]  out_chan;
  logic           out_ready = 1'b0;
  logic [15:0]    xfer_count;

  y_stream_mux #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan),
    .out_ready(out_ready), .xfer_count(xfer_count)
  );

  // clock
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int              m_ptr;
  bit              m_ov;
  logic [W-1:0]    m_data;
  int              m_chan;
  logic [15:0]     m_cnt;
  logic [CW+W-1:0] exp_q[$];
  logic [CW+W-1:0] mon_e;

  localparam logic [C*W-1:0] EXH_DATA = {8'h33, 8'h22, 8'h11, 8'h00};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_ov   = 1'b0;
    m_data = '0;
    m_chan = 0;
    m_cnt  = '0;
    exp_q.delete();
  endtask

  // One stimulus cycle: drive after the falling edge, check the current
  // (pre-edge) state against the model, then advance the model across the
  // coming rising edge.
  task automatic cycle(input bit md, input int s, input logic [C-1:0] v,
                       input logic [C*W-1:0] d, input bit rdy);
    int           cand;
    int           c;
    bit           g;
    bit           space;
    logic [C-1:0] one;
    logic [C-1:0] er;
    @(negedge clk);
    mode      = md;
    sel       = s[CW-1:0];
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    #2;
    one   = 1;
    space = !m_ov || rdy;
    g     = 1'b0;
    cand  = s;
    if (!md) begin
      g = v[s];
    end else begin
      for (int k = 0; k < C; k++) begin
        c = (m_ptr + k) % C;
        if (!g && v[c]) begin
          g    = 1'b1;
          cand = c;
        end
      end
    end
    er = (g && space) ? (one << cand) : '0;
    chk("in_ready", in_ready, er);
    chk("out_valid", out_valid, m_ov);
    chk("out_data", out_data, m_data);
    chk("out_chan", out_chan, m_chan);
    chk("xfer_count", xfer_count, m_cnt);
    if (g && space) begin
      m_data = d[cand*W +: W];
      m_chan = cand;
      m_ov   = 1'b1;
      m_ptr  = (cand + 1) % C;
      m_cnt  = m_cnt + 16'd1;
      exp_q.push_back({CW'(cand), m_data});
    end else if (m_ov && rdy) begin
      m_ov = 1'b0;
    end
  endtask

  // Look at the registers just after the edge that follows a cycle() call.
  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor: every drained word must be the oldest queued one
  always @(negedge clk) begin
    #3;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL drain_word got=%0h exp=none t=%0t", {out_chan, out_data}, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("drain_word", {out_chan, out_data}, mon_e);
      end
    end
  end

  initial begin
    int base;
    int n;
    model_reset();

    // Asynchronous reset with inputs that would otherwise be granted.
    mode = 1'b0; sel = '0; in_valid = '1; in_data = EXH_DATA; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_chan", out_chan, 0);
    chk("rst_xfer_count", xfer_count, 0);
    chk("rst_in_ready", in_ready, 0);
    after_edge();
    chk("rst_hold_valid", out_valid, 0);
    chk("rst_hold_ready", in_ready, 0);
    in_valid = '0;
    rst_n = 1'b1;

    // Manual select of channel 2, accepted on the first edge after reset.
    cycle(1'b0, 2, 4'b1111, {8'h33, 8'hA5, 8'h11, 8'h00}, 1'b1);
    chk("man_in_ready", in_ready, 4'b0100);
    after_edge();
    chk("man_out_data", out_data, 8'hA5);
    chk("man_out_chan", out_chan, 2);
    chk("man_xfer_count", xfer_count, 1);

    // Bring the pointer to 0, then check round-robin fairness.
    cycle(1'b0, 3, 4'b1000, EXH_DATA, 1'b1);
    base = m_cnt;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 0, 4'b1111, EXH_DATA, 1'b1);
      after_edge();
      chk("rr_out_chan", out_chan, i % 4);
    end
    chk("rr_xfer_count", xfer_count, base + 8);

    // Skip: pointer at 1 with only channels 0 and 3 requesting.
    cycle(1'b0, 0, 4'b0001, EXH_DATA, 1'b1);
    cycle(1'b1, 0, 4'b1001, EXH_DATA, 1'b1);
    after_edge();
    chk("skip_first", out_chan, 3);
    cycle(1'b1, 0, 4'b1001, EXH_DATA, 1'b1);
    after_edge();
    chk("skip_second", out_chan, 0);

    // Backpressure: register full (channel 0 word 8'h00), nothing moves.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 0, 4'b1111, {8'hD3, 8'hC2, 8'hB1, 8'hA0}, 1'b0);
      chk("bp_in_ready", in_ready, 0);
      after_edge();
      chk("bp_out_data", out_data, 8'h00);
      chk("bp_out_valid", out_valid, 1);
    end
    cycle(1'b1, 0, 4'b1111, {8'hD3, 8'hC2, 8'hB1, 8'hA0}, 1'b1);
    chk("bp_release_ready", in_ready, 4'b0010);
    after_edge();
    chk("bp_release_valid", out_valid, 1);
    chk("bp_release_data", out_data, 8'hB1);

    // Reset mid-operation with five words accepted and one held.
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = '0;
    model_reset();
    after_edge();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cycle(1'b0, i % 4, 4'b1111, EXH_DATA, 1'b1);
    after_edge();
    chk("pre_rst_count", xfer_count, 5);
    chk("pre_rst_valid", out_valid, 1);
    @(negedge clk);
    in_valid = 4'b1111;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_chan", out_chan, 0);
    chk("mid_rst_count", xfer_count, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    model_reset();
    in_valid = '0;
    after_edge();
    rst_n = 1'b1;
    cycle(1'b1, 0, 4'b1111, EXH_DATA, 1'b1);
    after_edge();
    chk("post_rst_chan", out_chan, 0);
    chk("post_rst_count", xfer_count, 1);

    // Every mode x sel x in_valid x out_ready combination.
    for (int md = 0; md < 2; md++)
      for (int s = 0; s < C; s++)
        for (int v = 0; v < 16; v++)
          for (int r = 0; r < 2; r++)
            cycle(md[0], s, v[C-1:0], EXH_DATA, r[0]);

    // Random traffic.
    for (int i = 0; i < 2000; i++)
      cycle($urandom_range(0, 1), $urandom_range(0, C - 1), C'($urandom_range(0, 15)),
            {$urandom, $urandom}, $urandom_range(0, 3) != 0);

    // Run the counter through its 16'hFFFF -> 0 wrap.
    n = 65536 - int'(m_cnt);
    for (int i = 0; i < n; i++) cycle(1'b1, 0, 4'b1111, C*W'($urandom), 1'b1);
    after_edge();
    chk("count_wrap", xfer_count, 0);

    // Drain whatever is left and make sure every queued word came out.
    cycle(1'b0, 0, 4'b0000, EXH_DATA, 1'b1);
    @(negedge clk);
    #4;
    chk("queue_empty", exp_q.size(), 0);
    chk("final_valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
